// File: rtl/ext_mem_loader_pkg.sv
// -----------------------------------------------------------------------------
// ext_mem_loader_pkg
// Shared definitions for the external memory loader:
//   - BYTE_W / WORD_W   : byte and word widths of the load and dump streams
//   - BYTES_PER_WORD    : bytes packed into (or unpacked from) one memory word
//   - state_e           : sequencer FSM states
// No ports (package).
// -----------------------------------------------------------------------------
package ext_mem_loader_pkg;

  localparam int BYTE_W         = 8;
  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = WORD_W / BYTE_W;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_RD   = 3'd3,
    ST_TX   = 3'd4,
    ST_DONE = 3'd5
  } state_e;

endpackage

// File: rtl/ext_mem_loader_byte_word_packer.sv
// -----------------------------------------------------------------------------
// byte_word_packer
// Assembles a little-endian word from a stream of bytes: the first byte of a
// word ends up in bits [7:0]. When the last byte of a word is accepted,
// word_valid pulses for exactly one cycle with the assembled word on
// word_data (word_data then holds until the next word completes).
//
// Ports:
//   clk, arst_n  : clock, asynchronous active-low reset (drops partial word)
//   clear        : synchronous restart of the byte count and partial word
//   byte_valid   : a byte is transferred this cycle
//   byte_data    : the byte
//   last_byte    : the next accepted byte completes a word
//   word_valid   : one-cycle pulse, word_data holds a new word
//   word_data    : most recently completed word
// -----------------------------------------------------------------------------
module byte_word_packer
  import ext_mem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              arst_n,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              last_byte,
  output logic              word_valid,
  output logic [WORD_W-1:0] word_data
);

  localparam int CNT_W = $clog2(BYTES_PER_WORD);

  logic [CNT_W-1:0]  count;
  logic [WORD_W-1:0] shift;
  logic [WORD_W-1:0] shift_next;

  // New bytes enter at the top and move down, so after a full word the first
  // byte sits in [7:0].
  assign shift_next = {byte_data, shift[WORD_W-1:BYTE_W]};
  assign last_byte  = (count == CNT_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      count      <= '0;
      shift      <= '0;
      word_valid <= 1'b0;
      word_data  <= '0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        count     <= '0;
        shift     <= '0;
        word_data <= '0;
      end else if (byte_valid) begin
        shift <= shift_next;
        // count wraps to 0 after the last byte of a word by design
        count <= count + CNT_W'(1);
        if (last_byte) begin
          word_valid <= 1'b1;
          word_data  <= shift_next;
        end
      end
    end
  end

endmodule

// File: rtl/ext_mem_loader.sv
// -----------------------------------------------------------------------------
// ext_mem_loader
// Sequencer that loads a program into instruction memory, runs the processor
// for a fixed number of cycles, then streams data memory back out.
//
//   IDLE --start--> LOAD : bytes in, packed into words, written to imem
//   LOAD -----------> RUN  : after the last load word is written
//   RUN  -----------> RD   : after RUN_CYCLES cycles of cpu_enable
//   RD   -----------> TX   : one-cycle dmem read issued
//   TX   -----------> RD   : word sent as 4 bytes, more words remain
//   TX   -----------> DONE : last word sent
//   DONE --start--> LOAD : new sequence, counters and addresses cleared
//
// Handshakes: a byte moves on in_valid && in_ready (load side) and on
// out_valid && out_ready (dump side); the producer holds data stable while
// its valid is high and the other side is not ready.
//
// Optional feature (macro LOADER_CHECKSUM_EN): after the last dump word, TX
// sends 4 more bytes, the 32-bit wrap-around sum of all loaded words,
// little-endian; DONE follows the 4th checksum byte.
//
// Ports:
//   clk, arst_n              : clock, asynchronous active-low reset
//   start                    : begin a sequence (honoured in IDLE and DONE)
//   in_valid/in_ready/in_data: load byte stream
//   out_valid/out_ready/out_data : dump byte stream
//   imem_addr/imem_wen/imem_wdata : instruction memory write port (byte addr)
//   dmem_addr/dmem_ren/dmem_rdata : data memory read port, 1-cycle latency
//   cpu_enable               : processor enable, high only in RUN
//   busy / done              : sequence in progress / sequence complete
// The FSM register is the signal 'state'.
// -----------------------------------------------------------------------------
module ext_mem_loader
  import ext_mem_loader_pkg::*;
#(
  parameter int LOAD_WORDS = 128,
  parameter int RUN_CYCLES = 1024,
  parameter int DUMP_WORDS = 64
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic [WORD_W-1:0] imem_addr,
  output logic              imem_wen,
  output logic [WORD_W-1:0] imem_wdata,
  output logic [WORD_W-1:0] dmem_addr,
  output logic              dmem_ren,
  input  logic [WORD_W-1:0] dmem_rdata,
  output logic              cpu_enable,
  output logic              busy,
  output logic              done
);

  // One spare bit so each counter can reach its parameter without wrapping.
  localparam int LW_W = $clog2(LOAD_WORDS) + 1;
  localparam int RC_W = $clog2(RUN_CYCLES) + 1;
  localparam int DW_W = $clog2(DUMP_WORDS) + 1;

  state_e state;
  state_e state_next;

  logic [LW_W-1:0]   load_cnt;
  logic              load_full;
  logic [RC_W-1:0]   run_cnt;
  logic [DW_W-1:0]   dump_cnt;
  logic [1:0]        byte_idx;
  logic [WORD_W-1:0] cap_word;
  logic              cap_pending;
  logic [WORD_W-1:0] tx_word;
  logic [BYTE_W-1:0] tx_byte;

  logic seq_start;
  logic in_fire;
  logic out_fire;
  logic last_word_written;
  logic run_last;
  logic dump_last;
  logic byte_last;

  logic              pk_last_byte;
  logic              pk_word_valid;
  logic [WORD_W-1:0] pk_word_data;

`ifdef LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] cks_sum;
  logic              cks_phase;
`endif

  assign seq_start         = start && (state == ST_IDLE || state == ST_DONE);
  assign in_fire           = in_valid && in_ready;
  assign out_fire          = out_valid && out_ready;
  assign last_word_written = pk_word_valid && (load_cnt == LW_W'(LOAD_WORDS - 1));
  assign run_last          = (run_cnt == RC_W'(RUN_CYCLES - 1));
  assign dump_last         = (dump_cnt == DW_W'(DUMP_WORDS - 1));
  assign byte_last         = (byte_idx == 2'd3);

  byte_word_packer u_packer (
    .clk        (clk),
    .arst_n     (arst_n),
    .clear      (seq_start),
    .byte_valid (in_fire),
    .byte_data  (in_data),
    .last_byte  (pk_last_byte),
    .word_valid (pk_word_valid),
    .word_data  (pk_word_data)
  );

  assign imem_wen   = pk_word_valid;
  assign imem_wdata = pk_word_data;
  assign imem_addr  = WORD_W'({load_cnt, 2'b00});
  assign dmem_addr  = WORD_W'({dump_cnt, 2'b00});

  // The read issued in RD returns during the first TX cycle; that cycle
  // shows dmem_rdata directly and the word is captured at its end, so the
  // first byte is presented without an extra bubble.
`ifdef LOADER_CHECKSUM_EN
  assign tx_word = cks_phase   ? cks_sum    :
                   cap_pending ? dmem_rdata : cap_word;
`else
  assign tx_word = cap_pending ? dmem_rdata : cap_word;
`endif
  assign tx_byte = tx_word[{byte_idx, 3'b000} +: BYTE_W];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_data   = '0;
    dmem_ren   = 1'b0;
    cpu_enable = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        busy     = 1'b1;
        // Stop accepting once the last word's final byte is in; LOAD lasts
        // one more cycle while that word is written.
        in_ready = !load_full;
        if (last_word_written) state_next = ST_RUN;
      end
      ST_RUN: begin
        busy       = 1'b1;
        cpu_enable = 1'b1;
        if (run_last) state_next = ST_RD;
      end
      ST_RD: begin
        busy       = 1'b1;
        dmem_ren   = 1'b1;
        state_next = ST_TX;
      end
      ST_TX: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = tx_byte;
        if (out_ready && byte_last) begin
`ifdef LOADER_CHECKSUM_EN
          if (cks_phase)      state_next = ST_DONE;
          else if (dump_last) state_next = ST_TX;
          else                state_next = ST_RD;
`else
          if (dump_last) state_next = ST_DONE;
          else           state_next = ST_RD;
`endif
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) state_next = ST_LOAD;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      load_cnt    <= '0;
      load_full   <= 1'b0;
      run_cnt     <= '0;
      dump_cnt    <= '0;
      byte_idx    <= '0;
      cap_word    <= '0;
      cap_pending <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      cks_sum     <= '0;
      cks_phase   <= 1'b0;
`endif
    end else if (seq_start) begin
      load_cnt    <= '0;
      load_full   <= 1'b0;
      run_cnt     <= '0;
      dump_cnt    <= '0;
      byte_idx    <= '0;
      cap_word    <= '0;
      cap_pending <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      cks_sum     <= '0;
      cks_phase   <= 1'b0;
`endif
    end else begin
      if (pk_word_valid) begin
        load_cnt <= load_cnt + LW_W'(1);
      end
      if (in_fire && pk_last_byte && (load_cnt == LW_W'(LOAD_WORDS - 1))) begin
        load_full <= 1'b1;
      end
`ifdef LOADER_CHECKSUM_EN
      if (pk_word_valid) begin
        cks_sum <= cks_sum + pk_word_data;
      end
`endif
      if (state == ST_RUN) begin
        run_cnt <= run_cnt + RC_W'(1);
      end
      if (state == ST_RD) begin
        cap_pending <= 1'b1;
      end
      if (state == ST_TX && cap_pending) begin
        cap_word    <= dmem_rdata;
        cap_pending <= 1'b0;
      end
      if (out_fire) begin
        // byte_idx wraps to 0 after byte 3 of each word by design
        byte_idx <= byte_idx + 2'd1;
        if (byte_last) begin
`ifdef LOADER_CHECKSUM_EN
          if (!cks_phase) begin
            if (dump_last) cks_phase <= 1'b1;
            else           dump_cnt  <= dump_cnt + DW_W'(1);
          end
`else
          if (!dump_last) dump_cnt <= dump_cnt + DW_W'(1);
`endif
        end
      end
    end
  end

endmodule

// File: doc/ext_mem_loader.md
EXT_MEM_LOADER -- requirements
Module: ext_mem_loader

Interface
REQ-001 Parameters SHALL be:
- LOAD_WORDS, 128: words written to instruction memory.
- RUN_CYCLES, 1024: cycles cpu_enable is held high.
- DUMP_WORDS, 64: words read back from data memory.
REQ-002 Ports SHALL be, one clock, reset asynchronous active-low:
- clk  in  1  clock
- arst_n  in  1  async reset, active low
- start  in  1  begin sequence (pulse)
- in_valid  in  1  load byte valid
- in_ready  out  1  load byte accepted
- in_data  in  8  load byte
- out_valid  out  1  dump byte valid
- out_ready  in  1  dump sink ready
- out_data  out  8  dump byte
- imem_addr  out  32  instruction memory ext address
- imem_wen  out  1  instruction memory ext write enable
- imem_wdata  out  32  instruction memory ext write word
- dmem_addr  out  32  data memory ext address
- dmem_ren  out  1  data memory ext read enable
- dmem_rdata  in  32  data memory ext read word
- cpu_enable  out  1  processor enable
- busy  out  1  sequence in progress
- done  out  1  sequence complete

Function
REQ-003 The FSM SHALL have states IDLE, LOAD, RUN, RD, TX, DONE.
- IDLE->LOAD on start.
- LOAD->RUN after word LOAD_WORDS-1 is written.
- RUN->RD after RUN_CYCLES cycles.
- RD->TX after one cycle.
- TX->RD after byte 3 of a word, if words remain.
- TX->DONE after byte 3 of the last word.
- DONE->LOAD on start.
REQ-004 In LOAD, in_ready SHALL be 1; a byte SHALL transfer on in_valid&&in_ready.
REQ-005 Bytes SHALL be assembled little-endian: the first byte goes to bits [7:0].
REQ-006 On the 4th byte, imem_wen SHALL pulse for exactly one cycle with the assembled word on imem_wdata.
REQ-007 imem_addr SHALL be a byte address starting at 0 and incrementing by 4 after each write.
REQ-008 In RUN, cpu_enable SHALL be 1 for exactly RUN_CYCLES consecutive cycles; it SHALL be 0 in every other state.
REQ-009 In RD, dmem_ren SHALL be 1 with dmem_addr = 4*word_index; dmem_rdata SHALL be captured on the following cycle, one-cycle read latency.
REQ-010 In TX, out_valid SHALL be 1 and out_data SHALL present the captured word bytes [7:0], [15:8], [23:16], [31:24] in order.
REQ-011 Each TX byte SHALL advance only on out_valid&&out_ready; out_data SHALL hold stable while out_ready is 0.
REQ-012 busy SHALL be 1 in LOAD, RUN, RD and TX; done SHALL be 1 only in DONE.
REQ-013 start SHALL be ignored outside IDLE and DONE.
REQ-014 in_valid outside LOAD SHALL be ignored, with in_ready 0.
REQ-015 Counters SHALL be sized $clog2 of their parameter plus 1 and SHALL never wrap within a sequence.
REQ-016 Re-entering LOAD from DONE SHALL clear all counters and restart addresses at 0.

Reset
REQ-017 On arst_n low, the FSM SHALL go to IDLE immediately, including mid-sequence.
REQ-018 During reset, all outputs and counters SHALL be 0 (in_ready, out_valid, imem_wen, dmem_ren, cpu_enable, busy, done).
REQ-019 Any partially assembled word SHALL be discarded on reset.

Configuration
REQ-020 With LOADER_CHECKSUM_EN defined, TX SHALL append 4 extra bytes after the last dump word.
- These bytes SHALL be the 32-bit wrap-around sum of all loaded words, little-endian.
- done SHALL assert only after the 4th checksum byte.
REQ-021 Without LOADER_CHECKSUM_EN, no checksum logic SHALL exist, and DONE SHALL follow the last dump byte.

Structure
REQ-022 A shared package SHALL hold the FSM state enum and the byte/word width constants (BYTE_W=8, WORD_W=32).
REQ-023 One sub-module, byte_word_packer (4-byte shift/assemble with count), SHALL be used for the LOAD path.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Load: LOAD_WORDS=2; bytes 78 56 34 12 EF BE AD DE -> imem writes 0x12345678@0, then 0xDEADBEEF@4, one-cycle wen each.
- Run: RUN_CYCLES=5 -> cpu_enable high exactly 5 cycles, then dmem_ren with dmem_addr=0.
- Dump: dmem word 0xCAFEF00D with out_ready toggling every cycle -> out_data 0D F0 FE CA, each byte held until accepted.
- Reset: arst_n low during byte 3 of LOAD, then restart -> all outputs 0; first write after restart is at address 0 with fresh data.
- Checksum: LOADER_CHECKSUM_EN, words 0xFFFFFFFF and 0x00000002 loaded -> trailing bytes 01 00 00 00, then done=1.
- Restart: start pulsed in RUN -> ignored; start pulsed in DONE -> new LOAD begins.
